// File: rtl/register_file_sb.sv
// Multi-port register file with write-through bypass and a per-register busy
// scoreboard that lets decode stall on RAW hazards against in-flight results.
module register_file_sb #(
  parameter int REG_WIDTH   = 16,
  parameter int REG_COUNT   = 16,
  parameter int READ_PORTS  = 3,
  parameter int WRITE_PORTS = 2,
  localparam int PTR_W      = $clog2(REG_COUNT)
) (
  input  logic                             clk,
  input  logic                             reset_RF_n,
  input  logic                             init_en,
  input  logic [PTR_W-1:0]                 init_ptr,
  input  logic [REG_WIDTH-1:0]             init_data,
  input  logic [READ_PORTS*PTR_W-1:0]      rd_ptr,
  output logic [READ_PORTS*REG_WIDTH-1:0]  rd_data,
  output logic [READ_PORTS-1:0]            rd_busy,
  input  logic [WRITE_PORTS-1:0]           wr_en,
  input  logic [WRITE_PORTS*PTR_W-1:0]     wr_ptr,
  input  logic [WRITE_PORTS*REG_WIDTH-1:0] wr_data,
  input  logic                             issue_en,
  input  logic [PTR_W-1:0]                 issue_ptr,
  input  logic                             flush,
  output logic                             any_busy
);

  logic [REG_WIDTH-1:0]   r_q [REG_COUNT];
  logic [REG_WIDTH-1:0]   r_d [REG_COUNT];
  logic [REG_COUNT-1:0]   busy_q;
  logic [REG_COUNT-1:0]   busy_d;
  logic [WRITE_PORTS-1:0] wr_match_s [REG_COUNT];
  logic [PTR_W-1:0]       rd_idx_s;
  logic [READ_PORTS*REG_WIDTH-1:0] rd_data_s;
  logic [READ_PORTS-1:0]  rd_busy_s;

  // Decode which writeback ports target each register.
  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      for (int p = 0; p < WRITE_PORTS; p++) begin
        wr_match_s[i][p] = wr_en[p] & (wr_ptr[p*PTR_W +: PTR_W] == PTR_W'(i));
      end
    end
  end

  // Next register contents and busy bits; later assignments carry higher priority.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < REG_COUNT; i++) begin
      r_d[i] = r_q[i];
      for (int p = 0; p < WRITE_PORTS; p++) begin
        r_d[i] = wr_match_s[i][p] ? wr_data[p*REG_WIDTH +: REG_WIDTH] : r_d[i];
      end
      r_d[i] = (init_en && (init_ptr == PTR_W'(i))) ? init_data : r_d[i];

      // A same-cycle issue beats the retiring writeback: the new producer owns it.
      if (flush) begin
        busy_d[i] = 1'b0;
      end else if (issue_en && (issue_ptr == PTR_W'(i))) begin
        busy_d[i] = 1'b1;
      end else if (|wr_match_s[i]) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
  end

  // Combinational read ports with writeback and init bypass.
  always_comb begin
    rd_data_s = {(READ_PORTS*REG_WIDTH){1'b0}};
    rd_busy_s = {READ_PORTS{1'b0}};
    rd_idx_s  = {PTR_W{1'b0}};
    for (int k = 0; k < READ_PORTS; k++) begin
      rd_idx_s = rd_ptr[k*PTR_W +: PTR_W];
      rd_data_s[k*REG_WIDTH +: REG_WIDTH] = r_q[rd_idx_s];
      for (int p = 0; p < WRITE_PORTS; p++) begin
        rd_data_s[k*REG_WIDTH +: REG_WIDTH] = wr_match_s[rd_idx_s][p] ?
            wr_data[p*REG_WIDTH +: REG_WIDTH] : rd_data_s[k*REG_WIDTH +: REG_WIDTH];
      end
      rd_data_s[k*REG_WIDTH +: REG_WIDTH] = (init_en && (init_ptr == rd_idx_s)) ?
          init_data : rd_data_s[k*REG_WIDTH +: REG_WIDTH];
      rd_busy_s[k] = busy_q[rd_idx_s] & ~(|wr_match_s[rd_idx_s]) & ~flush;
    end
  end

  // Bypass paths are silenced while reset is held so nothing leaks out.
  assign rd_data  = rd_data_s & {(READ_PORTS*REG_WIDTH){reset_RF_n}};
  assign rd_busy  = rd_busy_s & {READ_PORTS{reset_RF_n}};
  assign any_busy = |busy_q;

  // Register array and scoreboard state.
  always_ff @(posedge clk or negedge reset_RF_n) begin
    if (!reset_RF_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_q[i] <= {REG_WIDTH{1'b0}};
      end
      busy_q <= {REG_COUNT{1'b0}};
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_q[i] <= r_d[i];
      end
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: a behavioural model predicts every
// read-port sample, which is queued at drive time and compared after settling.
module tb_register_file_sb;
  localparam int W  = 16;
  localparam int N  = 16;
  localparam int RP = 3;
  localparam int WP = 2;
  localparam int PW = 4;

  logic            clk = 1'b0;
  logic            reset_RF_n;
  logic            init_en;
  logic [PW-1:0]   init_ptr;
  logic [W-1:0]    init_data;
  logic [RP*PW-1:0] rd_ptr;
  logic [RP*W-1:0] rd_data;
  logic [RP-1:0]   rd_busy;
  logic [WP-1:0]   wr_en;
  logic [WP*PW-1:0] wr_ptr;
  logic [WP*W-1:0] wr_data;
  logic            issue_en;
  logic [PW-1:0]   issue_ptr;
  logic            flush;
  logic            any_busy;

  typedef struct packed {
    logic [RP*W-1:0] d;
    logic [RP-1:0]   b;
    logic            a;
  } exp_t;

  exp_t exp_q[$];
  exp_t e, got;
  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_r [N];
  logic [N-1:0] m_busy;

  register_file_sb #(.REG_WIDTH(W), .REG_COUNT(N), .READ_PORTS(RP), .WRITE_PORTS(WP)) dut (
    .clk(clk), .reset_RF_n(reset_RF_n), .init_en(init_en), .init_ptr(init_ptr),
    .init_data(init_data), .rd_ptr(rd_ptr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_ptr(wr_ptr), .wr_data(wr_data), .issue_en(issue_en),
    .issue_ptr(issue_ptr), .flush(flush), .any_busy(any_busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t model_out();
    exp_t r;
    logic [PW-1:0] p;
    logic [W-1:0] d;
    logic hit;
    r = '0;
    if (reset_RF_n) begin
      for (int k = 0; k < RP; k++) begin
        p = rd_ptr[k*PW +: PW];
        d = m_r[p];
        hit = 1'b0;
        for (int q = 0; q < WP; q++) begin
          if (wr_en[q] && wr_ptr[q*PW +: PW] == p) begin
            d = wr_data[q*W +: W];
            hit = 1'b1;
          end
        end
        if (init_en && init_ptr == p) d = init_data;
        r.d[k*W +: W] = d;
        r.b[k] = m_busy[p] & ~hit & ~flush;
      end
      r.a = |m_busy;
    end
    return r;
  endfunction

  task automatic model_clock();
    if (!reset_RF_n) begin
      for (int i = 0; i < N; i++) m_r[i] = '0;
      m_busy = '0;
    end else begin
      for (int q = 0; q < WP; q++) begin
        if (wr_en[q]) begin
          m_r[wr_ptr[q*PW +: PW]] = wr_data[q*W +: W];
          m_busy[wr_ptr[q*PW +: PW]] = 1'b0;
        end
      end
      if (init_en) m_r[init_ptr] = init_data;
      if (issue_en) m_busy[issue_ptr] = 1'b1;
      if (flush) m_busy = '0;
    end
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    init_en = 1'b0; init_ptr = '0; init_data = '0;
    wr_en = '0; wr_ptr = '0; wr_data = '0;
    issue_en = 1'b0; issue_ptr = '0; flush = 1'b0;
  endtask

  task automatic test_reset();
    reset_RF_n = 1'b0;
    idle();
    rd_ptr = '0;
    model_clock();
    #2;
    wr_en = 2'b01; wr_ptr = {4'd0, 4'd0}; wr_data = {16'h0, 16'hFFFF};
    exp_q.push_back(model_out());
    #1;
    got = {rd_data, rd_busy, any_busy}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset_held: got %h exp %h", got, e);
    end
    @(negedge clk);
    idle();
    reset_RF_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      rd_ptr = {4'((3*c+2) % N), 4'((3*c+1) % N), 4'((3*c) % N)};
      exp_q.push_back(model_out());
      #1;
      got = {rd_data, rd_busy, any_busy}; e = exp_q.pop_front(); checks++;
      if (got !== e || got !== '0) begin
        errors++;
        $display("FAIL reset_read_%0d: got %h exp %h", c, got, e);
      end
      tick();
    end
  endtask

  task automatic test_bypass();
    for (int c = 0; c < 2; c++) begin
      idle();
      rd_ptr = {4'd0, 4'd0, 4'd5};
      if (c == 0) begin
        wr_en = 2'b01; wr_ptr = {4'd0, 4'd5}; wr_data = {16'h0, 16'hA5A5};
      end
      exp_q.push_back(model_out());
      #1;
      got = {rd_data, rd_busy, any_busy}; e = exp_q.pop_front(); checks++;
      if (got !== e || rd_data[15:0] !== 16'hA5A5) begin
        errors++;
        $display("FAIL bypass_%0d: got %h exp %h", c, got, e);
      end
      tick();
    end
  endtask

  task automatic test_write_priority();
    logic [W-1:0] want [4];
    want[0] = 16'h2222; want[1] = 16'h2222; want[2] = 16'h3333; want[3] = 16'h3333;
    for (int c = 0; c < 4; c++) begin
      idle();
      rd_ptr = {4'd3, 4'd3, 4'd3};
      if (c == 0 || c == 2) begin
        wr_en = 2'b11; wr_ptr = {4'd3, 4'd3}; wr_data = {16'h2222, 16'h1111};
      end
      if (c == 2) begin
        init_en = 1'b1; init_ptr = 4'd3; init_data = 16'h3333;
      end
      exp_q.push_back(model_out());
      #1;
      got = {rd_data, rd_busy, any_busy}; e = exp_q.pop_front(); checks++;
      if (got !== e || rd_data[47:32] !== want[c]) begin
        errors++;
        $display("FAIL write_prio_%0d: got %h exp %h", c, got, e);
      end
      tick();
    end
  endtask

  task automatic test_issue();
    logic [3:0] want_busy_any [4];
    want_busy_any[0] = 4'b0000; want_busy_any[1] = 4'b1111;
    want_busy_any[2] = 4'b0001; want_busy_any[3] = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      idle();
      rd_ptr = {4'd7, 4'd7, 4'd7};
      if (c == 0) begin issue_en = 1'b1; issue_ptr = 4'd7; end
      if (c == 2) begin wr_en = 2'b10; wr_ptr = {4'd7, 4'd0}; wr_data = {16'h7777, 16'h0}; end
      exp_q.push_back(model_out());
      #1;
      got = {rd_data, rd_busy, any_busy}; e = exp_q.pop_front(); checks++;
      if (got !== e || {rd_busy, any_busy} !== want_busy_any[c]) begin
        errors++;
        $display("FAIL issue_%0d: got %h exp %h", c, got, e);
      end
      tick();
    end
  endtask

  task automatic test_issue_wb_flush();
    for (int c = 0; c < 4; c++) begin
      idle();
      rd_ptr = {4'd2, 4'd9, 4'd9};
      if (c == 0) begin
        issue_en = 1'b1; issue_ptr = 4'd9;
        wr_en = 2'b01; wr_ptr = {4'd0, 4'd9}; wr_data = {16'h0, 16'hBEEF};
      end
      if (c == 2) begin
        flush = 1'b1; issue_en = 1'b1; issue_ptr = 4'd2;
      end
      exp_q.push_back(model_out());
      #1;
      got = {rd_data, rd_busy, any_busy}; e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL issue_wb_flush_%0d: got %h exp %h", c, got, e);
      end
      if (c == 1) begin
        checks++;
        if (rd_data[15:0] !== 16'hBEEF || rd_busy[0] !== 1'b1 || any_busy !== 1'b1) begin
          errors++;
          $display("FAIL issue_wb_same: got d=%h b=%b a=%b exp d=beef b=1 a=1", rd_data[15:0], rd_busy[0], any_busy);
        end
      end
      if (c == 3) begin
        checks++;
        if (rd_busy !== 3'b000 || any_busy !== 1'b0) begin
          errors++;
          $display("FAIL flush_issue: got b=%b a=%b exp b=000 a=0", rd_busy, any_busy);
        end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    idle();
    rd_ptr = {4'd6, 4'd4, 4'd1};
    wr_en = 2'b11; wr_ptr = {4'd4, 4'd1}; wr_data = {16'h4444, 16'h1234};
    issue_en = 1'b1; issue_ptr = 4'd6;
    tick();
    idle();
    issue_en = 1'b1; issue_ptr = 4'd1;
    tick();
    idle();
    exp_q.push_back(model_out());
    #1;
    got = {rd_data, rd_busy, any_busy}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL pre_async_reset: got %h exp %h", got, e);
    end
    #1;
    reset_RF_n = 1'b0;
    model_clock();
    exp_q.push_back(model_out());
    #1;
    got = {rd_data, rd_busy, any_busy}; e = exp_q.pop_front(); checks++;
    if (got !== e || got !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h exp %h", got, e);
    end
    @(negedge clk);
    reset_RF_n = 1'b1;
    exp_q.push_back(model_out());
    #1;
    got = {rd_data, rd_busy, any_busy}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL post_async_reset: got %h exp %h", got, e);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      idle();
      rd_ptr    = 12'($urandom);
      wr_en     = 2'($urandom);
      wr_ptr    = 8'($urandom);
      wr_data   = 32'($urandom);
      init_en   = ($urandom_range(0, 7) == 0);
      init_ptr  = 4'($urandom);
      init_data = 16'($urandom);
      issue_en  = ($urandom_range(0, 1) == 0);
      issue_ptr = 4'($urandom);
      flush     = ($urandom_range(0, 15) == 0);
      exp_q.push_back(model_out());
      #1;
      got = {rd_data, rd_busy, any_busy}; e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL random_%0d: got %h exp %h", c, got, e);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_write_priority();
    test_issue();
    test_issue_wb_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
# register_file_sb

Parametrised multi-port register file with a per-register scoreboard, for the core's D/W pipeline stages. Provides READ_PORTS combinational read ports with write-through bypass, WRITE_PORTS writeback ports with fixed priority, and a generalised init port that loads any register. A busy bit per register tracks in-flight results so the decode stage can stall on RAW hazards without a separate hazard unit.

## Interface
- REG_WIDTH, 16, data width of each register
- REG_COUNT, 16, number of registers (power of two, ≥2); PTR_W = clog2(REG_COUNT) derived
- READ_PORTS, 3, number of read ports
- WRITE_PORTS, 2, number of writeback ports; higher index = higher priority
- clk  in  1  core clock, all state updates on rising edge
- reset_RF_n  in  1  asynchronous, active-low reset
- init_en  in  1  load init_data into register init_ptr
- init_ptr  in  PTR_W  init target register
- init_data  in  REG_WIDTH  init value
- rd_ptr  in  READ_PORTS*PTR_W  read pointers, port k at bits [k*PTR_W +: PTR_W]
- rd_data  out  READ_PORTS*REG_WIDTH  read data, port k at [k*REG_WIDTH +: REG_WIDTH]
- rd_busy  out  READ_PORTS  register at rd_ptr[k] has a pending result
- wr_en  in  WRITE_PORTS  writeback valid per port
- wr_ptr  in  WRITE_PORTS*PTR_W  writeback destination per port
- wr_data  in  WRITE_PORTS*REG_WIDTH  writeback data per port
- issue_en  in  1  an instruction with a destination leaves decode
- issue_ptr  in  PTR_W  destination to mark busy
- flush  in  1  clear all busy bits (pipeline flush)
- any_busy  out  1  OR of all busy bits

## Operation
- State: r[REG_COUNT] of REG_WIDTH, busy[REG_COUNT] of 1 bit.
- Reset (reset_RF_n=0, asynchronous): all r = 0, all busy = 0; rd_busy = 0, any_busy = 0, rd_data = 0 while held.
- Register update per register i, priority high to low: init_en & init_ptr==i -> init_data; highest-index wr_en[p] with wr_ptr[p]==i -> wr_data[p]; else hold.
- init does not touch busy.
- Read port k, combinational: if init_en & init_ptr==rd_ptr[k] -> init_data; else if any wr_en[p] targets rd_ptr[k] -> data of highest such p; else r[rd_ptr[k]].
- Busy update per register i, priority high to low: flush -> 0; issue_en & issue_ptr==i -> 1; any wr_en targeting i -> 0; else hold.
- Issue and writeback to the same register in one cycle: busy = 1 (new producer owns it); data still written.
- Flush with issue in the same cycle: flush wins, busy all 0.
- rd_busy[k] = busy[rd_ptr[k]] & ~(any wr_en targeting rd_ptr[k]) & ~flush; issue in the current cycle is not reflected until next cycle.
- any_busy = OR of registered busy (not bypassed).
- Writeback to a non-busy register is legal: data written, busy stays 0.

## Timing
- Read latency 0 cycles (combinational from rd_ptr, wr_*, init_*).
- Write, init, issue, flush: take effect at the next rising clk; visible in r/busy one cycle later, in rd_data/rd_busy in the same cycle via bypass (except issue).
- Reset asserted mid-cycle clears state immediately; deassertion is synchronous to the design's reset synchroniser (outside this block).
- No handshake stalls; all inputs sampled every cycle.

## Test plan
- Reset then read all 16 registers on 3 ports -> rd_data = 0, rd_busy = 0, any_busy = 0.
- wr_en=2'b01, wr_ptr0=5, wr_data0=16'hA5A5, rd_ptr0=5 same cycle -> rd_data0 = 16'hA5A5 immediately; next cycle still 16'hA5A5 with wr_en=0.
- Both ports write reg 3 (port0 16'h1111, port1 16'h2222) -> reg 3 = 16'h2222; add init_en to reg 3 with 16'h3333 -> reg 3 = 16'h3333.
- issue_en reg 7 -> rd_busy for reg 7 = 0 same cycle, 1 next cycle, any_busy = 1; writeback reg 7 -> rd_busy 0 in that cycle, busy cleared next cycle.
- Issue reg 9 and writeback reg 9 same cycle -> next cycle busy[9] = 1, r[9] = written value; then flush with issue reg 2 -> all busy 0, any_busy = 0.
- Assert reset_RF_n=0 between clock edges with several regs written and busy -> all rd_data and busy drop to 0 without a clock edge.
